// File: rtl/mac_batch_arbiter_if.sv
// Client and accelerator signal bundle for mac_batch_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mac_batch_arbiter_if #(
    parameter int OPW = 16,
    parameter int RW  = 34
);
    // Client request side
    logic               req_valid_0;
    logic               req_valid_1;
    logic               req_ready_0;
    logic               req_ready_1;
    logic [4*OPW-1:0]   req_a_0;
    logic [4*OPW-1:0]   req_a_1;
    logic [4*OPW-1:0]   req_b_0;
    logic [4*OPW-1:0]   req_b_1;

    // Client result side
    logic               res_valid_0;
    logic               res_valid_1;
    logic [RW-1:0]      res_data;

    // Accelerator MAC port
    logic               EN_mac;
    logic               RDY_mac;
    logic [OPW-1:0]     mac_vectA_0;
    logic [OPW-1:0]     mac_vectA_1;
    logic [OPW-1:0]     mac_vectA_2;
    logic [OPW-1:0]     mac_vectA_3;
    logic [OPW-1:0]     mac_vectB_0;
    logic [OPW-1:0]     mac_vectB_1;
    logic [OPW-1:0]     mac_vectB_2;
    logic [OPW-1:0]     mac_vectB_3;

    // Accelerator block-read / read-back port
    logic               EN_blockRead;
    logic               RDY_blockRead;
    logic               VALID_memVal;
    logic [RW-1:0]      memVal_data;

    // Status
    logic               owner;
    logic               busy;
    logic               err_spurious;

    modport slave (
        input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
        output req_ready_0, req_ready_1,
        output res_valid_0, res_valid_1, res_data,
        output EN_mac,
        input  RDY_mac,
        output mac_vectA_0, mac_vectA_1, mac_vectA_2, mac_vectA_3,
        output mac_vectB_0, mac_vectB_1, mac_vectB_2, mac_vectB_3,
        output EN_blockRead,
        input  RDY_blockRead, VALID_memVal, memVal_data,
        output owner, busy, err_spurious
    );

    modport master (
        output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
        input  req_ready_0, req_ready_1,
        input  res_valid_0, res_valid_1, res_data,
        input  EN_mac,
        output RDY_mac,
        input  mac_vectA_0, mac_vectA_1, mac_vectA_2, mac_vectA_3,
        input  mac_vectB_0, mac_vectB_1, mac_vectB_2, mac_vectB_3,
        input  EN_blockRead,
        output RDY_blockRead, VALID_memVal, memVal_data,
        input  owner, busy, err_spurious
    );
endinterface

// File: rtl/mac_batch_arbiter.sv
// Batch-granular arbiter sharing one dnn_accelerator MAC buffer between two
// clients: a grant covers BATCH issued dot products, the block read that
// follows, and the BATCH read-back beats routed to the owning client.
module mac_batch_arbiter #(
    parameter int OPW   = 16,
    parameter int RW    = 34,
    parameter int BATCH = 64,
    parameter int CW    = 7
) (
    input logic              CLK,
    input logic              RST_N,
    mac_batch_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_FULL,
        READ,
        DRAIN
    } stateT;

    stateT            state;
    stateT            nextState;
    logic             ownerQ;
    logic [CW-1:0]    issueCnt;
    logic [CW-1:0]    resCnt;
    logic             errQ;

    logic             anyReq;
    logic             grant;
    logic             lastIssue;
    logic             lastRes;
    logic             ownerValid;
    logic             macFire;
    logic             drainBeat;
    logic [4*OPW-1:0] ownerA;
    logic [4*OPW-1:0] ownerB;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; grant prefers the client that did not hold the last batch
    always_comb begin
        anyReq    = bus.req_valid_0 | bus.req_valid_1;
        grant     = (bus.req_valid_0 & bus.req_valid_1) ? ~ownerQ : bus.req_valid_1;
        lastIssue = (issueCnt == CW'(BATCH - 1));
        lastRes   = (resCnt == CW'(BATCH - 1));
        nextState = state;
        unique case (state)
            IDLE:      if (anyReq) nextState = ISSUE;
            ISSUE:     if (macFire && lastIssue) nextState = WAIT_FULL;
            WAIT_FULL: if (bus.RDY_blockRead) nextState = READ;
            READ:      nextState = DRAIN;
            DRAIN:     if (drainBeat && lastRes) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Output logic: owner mux, issue/read strobes, result routing, status
    always_comb begin
        ownerValid = ownerQ ? bus.req_valid_1 : bus.req_valid_0;
        ownerA     = ownerQ ? bus.req_a_1 : bus.req_a_0;
        ownerB     = ownerQ ? bus.req_b_1 : bus.req_b_0;
        macFire    = (state == ISSUE) && ownerValid && bus.RDY_mac;
        drainBeat  = (state == DRAIN) && bus.VALID_memVal;

        bus.EN_mac      = macFire;
        bus.req_ready_0 = macFire && !ownerQ;
        bus.req_ready_1 = macFire && ownerQ;

        bus.mac_vectA_0 = ownerA[0*OPW +: OPW];
        bus.mac_vectA_1 = ownerA[1*OPW +: OPW];
        bus.mac_vectA_2 = ownerA[2*OPW +: OPW];
        bus.mac_vectA_3 = ownerA[3*OPW +: OPW];
        bus.mac_vectB_0 = ownerB[0*OPW +: OPW];
        bus.mac_vectB_1 = ownerB[1*OPW +: OPW];
        bus.mac_vectB_2 = ownerB[2*OPW +: OPW];
        bus.mac_vectB_3 = ownerB[3*OPW +: OPW];

        bus.EN_blockRead = (state == READ);

        bus.res_valid_0 = drainBeat && !ownerQ;
        bus.res_valid_1 = drainBeat && ownerQ;
        bus.res_data    = bus.memVal_data;

        bus.owner        = ownerQ;
        bus.busy         = (state != IDLE);
        bus.err_spurious = errQ;
    end

    // Grant owner, batch counters and sticky spurious-beat flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ownerQ   <= 1'b1;
            issueCnt <= '0;
            resCnt   <= '0;
            errQ     <= 1'b0;
        end else begin
            if (state == IDLE && anyReq) begin
                ownerQ <= grant;
            end
            if (macFire) begin
                issueCnt <= lastIssue ? '0 : issueCnt + 1'b1;
            end
            if (drainBeat) begin
                resCnt <= lastRes ? '0 : resCnt + 1'b1;
            end
            if (bus.VALID_memVal && state != DRAIN) begin
                errQ <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_batch_arbiter.sv
// Scoreboard bench for mac_batch_arbiter with a behavioural accelerator model.
module tb_mac_batch_arbiter;

    localparam int OPW   = 16;
    localparam int RW    = 34;
    localparam int BATCH = 64;
    localparam int CW    = 7;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    mac_batch_arbiter_if #(.OPW(OPW), .RW(RW)) bus ();

    mac_batch_arbiter #(.OPW(OPW), .RW(RW), .BATCH(BATCH), .CW(CW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int passCnt  = 0;
    int checkCnt = 0;

    logic [RW-1:0] expQ0[$];
    logic [RW-1:0] expQ1[$];
    logic [RW-1:0] res0Log[$];
    int            ownerLog[$];
    int            res0Cnt = 0;
    int            res1Cnt = 0;
    int            brCnt = 0;
    int            issuedTotal = 0;
    int            stallAt = -1;
    int            stallSeen = 0;
    int            spurReqCnt = 0;
    int            spurDone = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [4*OPW-1:0] opA(input int k, input int c);
        logic [4*OPW-1:0] v;
        for (int e = 0; e < 4; e++) v[e*OPW +: OPW] = OPW'(k + e + 1 + c * 300);
        return v;
    endfunction

    function automatic logic [4*OPW-1:0] opB(input int k, input int c);
        logic [4*OPW-1:0] v;
        for (int e = 0; e < 4; e++) v[e*OPW +: OPW] = OPW'(k + e + 1 + c * 5);
        return v;
    endfunction

    function automatic logic [RW-1:0] dotVec(input logic [4*OPW-1:0] a, input logic [4*OPW-1:0] b);
        logic [63:0] s;
        s = 0;
        for (int e = 0; e < 4; e++) s += 64'(a[e*OPW +: OPW]) * 64'(b[e*OPW +: OPW]);
        return RW'(s);
    endfunction

    task automatic setReq(input int c, input logic v, input logic [4*OPW-1:0] a, input logic [4*OPW-1:0] b);
        if (c == 0) begin
            bus.req_valid_0 = v; bus.req_a_0 = a; bus.req_b_0 = b;
        end else begin
            bus.req_valid_1 = v; bus.req_a_1 = a; bus.req_b_1 = b;
        end
    endtask

    // Client driver: offers n operand sets, optionally withdrawing valid for
    // dropLen cycles after dropAt sets were accepted; pushes expected results.
    task automatic driveClient(input int c, input int n, input int dropAt, input int dropLen);
        int  k = 0;
        int  budget = 0;
        bit  dropped = 0;
        logic rdy;
        while (k < n) begin
            if (!dropped && dropLen > 0 && k == dropAt) begin
                dropped = 1;
                setReq(c, 1'b0, '0, '0);
                for (int d = 0; d < dropLen; d++) begin
                    @(negedge CLK);
                    check("drop_en_mac", bus.EN_mac, 0);
                    check("drop_owner", bus.owner, c);
                    @(posedge CLK); #1;
                end
            end
            setReq(c, 1'b1, opA(k, c), opB(k, c));
            @(negedge CLK);
            rdy = (c == 0) ? bus.req_ready_0 : bus.req_ready_1;
            if (rdy) begin
                if (c == 0) expQ0.push_back(dotVec(opA(k, c), opB(k, c)));
                else        expQ1.push_back(dotVec(opA(k, c), opB(k, c)));
                k++;
                budget = 0;
            end else begin
                budget++;
                if (budget > 3000) begin
                    check("client_accept_timeout", k, n);
                    break;
                end
            end
            @(posedge CLK); #1;
        end
        setReq(c, 1'b0, '0, '0);
    endtask

    task automatic waitCount(input int c, input int target, input string name);
        int cyc = 0;
        while (((c == 0) ? res0Cnt : res1Cnt) < target && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
        end
        check(name, (c == 0) ? res0Cnt : res1Cnt, target);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_owner"}, bus.owner, 1);
        check({tag, "_en_mac"}, bus.EN_mac, 0);
        check({tag, "_en_blockread"}, bus.EN_blockRead, 0);
        check({tag, "_req_ready"}, {bus.req_ready_1, bus.req_ready_0}, 0);
        check({tag, "_res_valid"}, {bus.res_valid_1, bus.res_valid_0}, 0);
        check({tag, "_err"}, bus.err_spurious, 0);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checkResetValues(tag);
        expQ0.delete();
        expQ1.delete();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Accelerator model: buffers dot products of issued operands, reports
    // full, replays the buffer after the block read, injects stalls/spurious beats.
    initial begin
        logic [4*OPW-1:0] sA, sB;
        logic sEn, sBr, sOwner, draining;
        int   stallLeft = 0;
        int   stallDoneAt = -1;
        logic [RW-1:0] accBuf[$];
        draining = 0;
        bus.RDY_mac = 1'b1;
        bus.RDY_blockRead = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data = '0;
        forever begin
            @(negedge CLK);
            sEn = bus.EN_mac;
            sBr = bus.EN_blockRead;
            sOwner = bus.owner;
            sA = {bus.mac_vectA_3, bus.mac_vectA_2, bus.mac_vectA_1, bus.mac_vectA_0};
            sB = {bus.mac_vectB_3, bus.mac_vectB_2, bus.mac_vectB_1, bus.mac_vectB_0};
            if (RST_N && !bus.RDY_mac) begin
                stallSeen++;
                check("stall_en_mac", bus.EN_mac, 0);
                check("stall_req_ready", {bus.req_ready_1, bus.req_ready_0}, 0);
            end
            @(posedge CLK); #1;
            if (!RST_N) begin
                accBuf.delete();
                draining = 0;
                stallLeft = 0;
                bus.VALID_memVal = 1'b0;
                bus.RDY_blockRead = 1'b0;
                bus.RDY_mac = 1'b1;
                continue;
            end
            if (sEn) begin
                accBuf.push_back(dotVec(sA, sB));
                issuedTotal++;
            end
            if (sBr) begin
                brCnt++;
                check("blockread_batch_size", accBuf.size(), BATCH);
                check("blockread_single_pulse", draining, 0);
                ownerLog.push_back(int'(sOwner));
                draining = 1;
            end
            bus.VALID_memVal = 1'b0;
            if (draining && accBuf.size() > 0) begin
                bus.VALID_memVal = 1'b1;
                bus.memVal_data = accBuf.pop_front();
                if (accBuf.size() == 0) draining = 0;
            end else if (spurReqCnt > spurDone) begin
                bus.VALID_memVal = 1'b1;
                bus.memVal_data = RW'(12345);
                spurDone++;
            end
            if (stallAt >= 0 && issuedTotal == stallAt && stallDoneAt != stallAt) begin
                stallLeft = 5;
                stallDoneAt = stallAt;
            end
            bus.RDY_mac = (stallLeft == 0);
            if (stallLeft > 0) stallLeft--;
            bus.RDY_blockRead = !draining && accBuf.size() == BATCH;
        end
    end

    // Result monitor: every presented beat is matched against the owning client's queue
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                if (bus.res_valid_0 && bus.res_valid_1) check("res_valid_both", 1, 0);
                if (bus.res_valid_0) begin
                    if (expQ0.size() == 0) check("res0_unexpected", 1, 0);
                    else check("res0_data", bus.res_data, expQ0.pop_front());
                    res0Log.push_back(bus.res_data);
                    res0Cnt++;
                end
                if (bus.res_valid_1) begin
                    if (expQ1.size() == 0) check("res1_unexpected", 1, 0);
                    else check("res1_data", bus.res_data, expQ1.pop_front());
                    res1Cnt++;
                end
                if (bus.busy) check("nonowner_ready", bus.owner ? bus.req_ready_0 : bus.req_ready_1, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, b1, br, sb;
        setReq(0, 1'b0, '0, '0);
        setReq(1, 1'b0, '0, '0);
        #1 RST_N = 1'b0;
        #1 checkResetValues("por");
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Lone client 0, spec operand pattern
        b0 = res0Cnt; b1 = res1Cnt; br = brCnt;
        res0Log.delete();
        driveClient(0, 64, -1, 0);
        waitCount(0, b0 + 64, "t1_res0_count");
        repeat (3) @(negedge CLK);
        check("t1_blockread_pulses", brCnt - br, 1);
        check("t1_res1_count", res1Cnt - b1, 0);
        check("t1_beat0", (res0Log.size() > 0) ? res0Log[0] : '1, 30);
        check("t1_beat63", (res0Log.size() > 63) ? res0Log[63] : '1,
              64*64 + 65*65 + 66*66 + 67*67);
        check("t1_expq_empty", expQ0.size(), 0);
        check("t1_owner", bus.owner, 0);

        // Both clients continuously, 4 batches
        pulseReset("t2_rst");
        ownerLog.delete();
        b0 = res0Cnt; b1 = res1Cnt;
        fork
            driveClient(0, 128, -1, 0);
            driveClient(1, 128, -1, 0);
        join
        waitCount(0, b0 + 128, "t2_res0_count");
        waitCount(1, b1 + 128, "t2_res1_count");
        check("t2_batches", ownerLog.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_owner_seq", (i < ownerLog.size()) ? ownerLog[i] : 2, i % 2);

        // Owner withdraws valid for 10 cycles after 20 accepted sets
        b0 = res0Cnt;
        driveClient(0, 64, 20, 10);
        waitCount(0, b0 + 64, "t3_res0_count");
        check("t3_expq_empty", expQ0.size(), 0);
        check("t3_owner", bus.owner, 0);

        // RDY_mac stalled 5 cycles mid-batch, client 1 alone
        b1 = res1Cnt; sb = stallSeen;
        stallAt = issuedTotal + 30;
        driveClient(1, 64, -1, 0);
        waitCount(1, b1 + 64, "t4_res1_count");
        check("t4_stall_cycles", stallSeen - sb, 5);
        check("t4_expq_empty", expQ1.size(), 0);
        check("t4_err_clear", bus.err_spurious, 0);

        // Spurious read-back beat in IDLE
        repeat (3) @(negedge CLK);
        b0 = res0Cnt; b1 = res1Cnt;
        check("t5_err_before", bus.err_spurious, 0);
        spurReqCnt++;
        for (int i = 0; i < 50 && spurDone < spurReqCnt; i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        check("t5_err_set", bus.err_spurious, 1);
        check("t5_no_results", (res0Cnt - b0) + (res1Cnt - b1), 0);
        repeat (10) @(negedge CLK);
        check("t5_err_sticky", bus.err_spurious, 1);
        check("t5_busy", bus.busy, 0);

        // Reset in the middle of DRAIN, then a fresh batch
        pulseReset("t6_pre");
        b0 = res0Cnt;
        driveClient(0, 64, -1, 0);
        waitCount(0, b0 + 30, "t6_res0_partial");
        #2 RST_N = 1'b0;
        #1 checkResetValues("t6_mid_drain");
        expQ0.delete();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        b0 = res0Cnt;
        driveClient(0, 64, -1, 0);
        waitCount(0, b0 + 64, "t6_res0_count");
        check("t6_expq_empty", expQ0.size(), 0);
        check("t6_err", bus.err_spurious, 0);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
